line_seg_fifo: RTL and testbench



---
 rtl/avg_pkg.sv | 16 +
 rtl/line_seg_fifo_lsq_ptr.sv | 24 ++
 rtl/line_seg_fifo.sv | 105 ++++++++++
 tb/tb_line_seg_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/avg_pkg.sv
// Shared AVG definitions: default coordinate/colour widths and the
// line-segment record passed from the vector core to the rasteriser.
package avg_pkg;

    localparam int COORD_W_DEF = 11;
    localparam int COLOR_W_DEF = 3;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] start_x;
        logic [COORD_W_DEF-1:0] start_y;
        logic [COORD_W_DEF-1:0] end_x;
        logic [COORD_W_DEF-1:0] end_y;
        logic [COLOR_W_DEF-1:0] color;
    } line_seg_t;

endpackage

// File: rtl/line_seg_fifo_lsq_ptr.sv
// lsq_ptr: wrap-bit queue pointer with increment and synchronous clear.
// The MSB is the wrap bit; arithmetic wraps silently modulo 2**W.
module lsq_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Pointer register: clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/line_seg_fifo.sv
// line_seg_fifo: show-ahead segment queue between the AVG core and the
// line rasteriser. Optional dropped-push counter enabled by the macro
// LSQ_OVF_CNT_EN (adds the ovf_cnt port).
module line_seg_fifo
    import avg_pkg::*;
#(
    parameter int COORD_W   = COORD_W_DEF,
    parameter int COLOR_W   = COLOR_W_DEF,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [COORD_W-1:0]      wr_start_x,
    input  logic [COORD_W-1:0]      wr_start_y,
    input  logic [COORD_W-1:0]      wr_end_x,
    input  logic [COORD_W-1:0]      wr_end_y,
    input  logic [COLOR_W-1:0]      wr_color,
    input  logic                    rd_en,
    output logic [COORD_W-1:0]      rd_start_x,
    output logic [COORD_W-1:0]      rd_start_y,
    output logic [COORD_W-1:0]      rd_end_x,
    output logic [COORD_W-1:0]      rd_end_y,
    output logic [COLOR_W-1:0]      rd_color,
    output logic                    full,
    output logic                    almost_full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef LSQ_OVF_CNT_EN
    ,
    output logic [15:0]             ovf_cnt
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int SEG_W = 4 * COORD_W + COLOR_W;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [SEG_W-1:0] mem [DEPTH];
    logic [SEG_W-1:0] head;
    logic             push;
    logic             pop;

    // Flags and occupancy are pure functions of the registered pointers.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = (count >= PW'(AFULL_LVL));

    // A push into a full queue is still accepted when a pop frees the head slot.
    assign push = wr_en && (!full || rd_en);
    assign pop  = rd_en && !empty;

    lsq_ptr #(.W(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    lsq_ptr #(.W(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Segment storage: written on accepted pushes, never reset or cleared.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= {wr_start_x, wr_start_y, wr_end_x, wr_end_y, wr_color};
        end
    end

    // Show-ahead head entry.
    assign head       = mem[rd_ptr[AW-1:0]];
    assign rd_start_x = head[SEG_W-1 -: COORD_W];
    assign rd_start_y = head[SEG_W-1-COORD_W -: COORD_W];
    assign rd_end_x   = head[COLOR_W+2*COORD_W-1 -: COORD_W];
    assign rd_end_y   = head[COLOR_W +: COORD_W];
    assign rd_color   = head[COLOR_W-1:0];

`ifdef LSQ_OVF_CNT_EN
    logic drop;

    // A flush cycle discards everything, so it is not counted as a drop.
    assign drop = wr_en && full && !rd_en && !flush;

    // Saturating dropped-push counter, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (drop && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_line_seg_fifo.sv
// Self-checking bench for line_seg_fifo (DEPTH=16, AFULL_LVL=14).
// Checks ovf_cnt only when LSQ_OVF_CNT_EN is defined.
module tb_line_seg_fifo;
    import avg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_en;
    logic        rd_en;
    logic [10:0] wr_start_x, wr_start_y, wr_end_x, wr_end_y;
    logic [2:0]  wr_color;
    logic [10:0] rd_start_x, rd_start_y, rd_end_x, rd_end_y;
    logic [2:0]  rd_color;
    logic        full, almost_full, empty;
    logic [4:0]  count;
`ifdef LSQ_OVF_CNT_EN
    logic [15:0] ovf_cnt;
`endif

    line_seg_fifo #(
        .COORD_W   (11),
        .COLOR_W   (3),
        .DEPTH     (16),
        .AFULL_LVL (14)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_start_x  (wr_start_x),
        .wr_start_y  (wr_start_y),
        .wr_end_x    (wr_end_x),
        .wr_end_y    (wr_end_y),
        .wr_color    (wr_color),
        .rd_en       (rd_en),
        .rd_start_x  (rd_start_x),
        .rd_start_y  (rd_start_y),
        .rd_end_x    (rd_end_x),
        .rd_end_y    (rd_end_y),
        .rd_color    (rd_color),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty),
        .count       (count)
`ifdef LSQ_OVF_CNT_EN
        ,
        .ovf_cnt     (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic      wr;
        logic      rd;
        logic      fl;
        line_seg_t din;
        int        e_count;
        logic      chk_head;
        line_seg_t e_head;
        int        e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur_ovf = 0;

    function automatic line_seg_t mk(input int i);
        line_seg_t s;
        s.start_x = 11'(100 + i);
        s.start_y = 11'(200 + i);
        s.end_x   = 11'(300 + i);
        s.end_y   = 11'(400 + i);
        s.color   = 3'(i % 8);
        return s;
    endfunction

    task automatic add(input logic wr, input logic rd, input line_seg_t din,
                       input int e_count, input logic chk, input line_seg_t e_head);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = 1'b0; v.din = din;
        v.e_count = e_count; v.chk_head = chk; v.e_head = e_head; v.e_ovf = cur_ovf;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic fl, input line_seg_t s);
        wr_en = wr; rd_en = rd; flush = fl;
        wr_start_x = s.start_x; wr_start_y = s.start_y;
        wr_end_x = s.end_x; wr_end_y = s.end_y; wr_color = s.color;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic line_seg_t head_now();
        line_seg_t h;
        h.start_x = rd_start_x; h.start_y = rd_start_y;
        h.end_x = rd_end_x; h.end_y = rd_end_y; h.color = rd_color;
        return h;
    endfunction

    task automatic check_occ(input string tag, input int e_count);
        check({tag, ".count"}, 64'(count), 64'(e_count));
        check({tag, ".empty"}, 64'(empty), 64'(e_count == 0));
        check({tag, ".full"}, 64'(full), 64'(e_count == 16));
        check({tag, ".afull"}, 64'(almost_full), 64'(e_count >= 14));
    endtask

    initial begin
        line_seg_t z;
        line_seg_t seg0;
        z = '0;
        seg0.start_x = 11'd10; seg0.start_y = 11'd20;
        seg0.end_x = 11'd30; seg0.end_y = 11'd40; seg0.color = 3'd5;

        // Single push then pop.
        add(1, 0, seg0, 1, 1, seg0);
        add(0, 1, z, 0, 0, z);
        // Fill 16 distinct segments; head stays segment 0.
        for (int k = 0; k < 16; k++) add(1, 0, mk(k), k + 1, 1, mk(0));
        // 17th push into a full queue is dropped.
        cur_ovf = 1;
        add(1, 0, mk(99), 16, 1, mk(0));
        // Push X with pop while full.
        add(1, 1, mk(50), 16, 1, mk(1));
        // 15 pops: heads seg2..seg15, then X.
        for (int j = 1; j <= 15; j++) add(0, 1, z, 16 - j, 1, (j == 15) ? mk(50) : mk(j + 1));
        add(0, 1, z, 0, 0, z);
        // Push Y with rd_en on an empty queue: pop ignored.
        add(1, 1, mk(60), 1, 1, mk(60));
        add(0, 1, z, 0, 0, z);
        // Pop on empty is ignored.
        add(0, 1, z, 0, 0, z);

        rst = 1'b1;
        drive(0, 0, 0, z);
        repeat (2) @(posedge clk);
        #1;
        check_occ("reset", 0);
`ifdef LSQ_OVF_CNT_EN
        check("reset.ovf", 64'(ovf_cnt), 64'd0);
`endif
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].din);
            step();
            check_occ($sformatf("vec%0d", i), vecs[i].e_count);
            if (vecs[i].chk_head)
                check($sformatf("vec%0d.head", i), 64'(head_now()), 64'(vecs[i].e_head));
`ifdef LSQ_OVF_CNT_EN
            check($sformatf("vec%0d.ovf", i), 64'(ovf_cnt), 64'(vecs[i].e_ovf));
`endif
        end

        // 40 push/pop pairs: pointers wrap, order preserved, count <= 1.
        for (int k = 0; k < 40; k++) begin
            drive(1, 0, 0, mk(200 + k));
            step();
            check($sformatf("wrap%0d.count1", k), 64'(count), 64'd1);
            check($sformatf("wrap%0d.head", k), 64'(head_now()), 64'(mk(200 + k)));
            drive(0, 1, 0, z);
            step();
            check($sformatf("wrap%0d.empty", k), 64'(empty), 64'd1);
        end

        // Flush together with wr_en while 8 entries are queued.
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 0, mk(300 + k));
            step();
        end
        check_occ("preflush", 8);
        drive(1, 0, 1, mk(400));
        step();
        check_occ("flush", 0);
`ifdef LSQ_OVF_CNT_EN
        check("flush.ovf", 64'(ovf_cnt), 64'd1);
`endif
        drive(0, 0, 0, z);

        // Asynchronous reset mid-burst with 8 entries queued.
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 0, mk(500 + k));
            step();
        end
        check_occ("prerst", 8);
        drive(1, 0, 0, mk(508));
        #2 rst = 1'b1;
        #1;
        check_occ("async_rst", 0);
`ifdef LSQ_OVF_CNT_EN
        check("async_rst.ovf", 64'(ovf_cnt), 64'd0);
`endif
        drive(0, 0, 0, z);
        step();
        rst = 1'b0;
        drive(1, 0, 0, mk(77));
        step();
        check_occ("post_rst", 1);
        check("post_rst.head", 64'(head_now()), 64'(mk(77)));
        drive(0, 1, 0, z);
        step();
        check_occ("post_rst_pop", 0);
        drive(0, 0, 0, z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
